// File: rtl/upscale_stream_out_pkg.sv
// Shared constants for the 3x upscaler output path.
// Holds the pixel width and the scale factor used to derive output raster dimensions.
package upscale_stream_out_pkg;
  localparam int PIX_W = 24;
  localparam int SCALE = 3;

  function automatic int out_dim(input int n);
    return SCALE * n;
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
// Reads and writes are qualified internally, so callers may drive raw requests.
module sync_fifo_fwft #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_s;
  logic             rd_ok_s;
  logic             wr_ok_s;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_s = wr_ptr_q - rd_ptr_q;
  assign level   = LW'(count_s);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  // A full FIFO still takes a write when the head slot is leaving this cycle.
  assign rd_ok_s = rd_en && !empty;
  assign wr_ok_s = wr_en && (!full || rd_ok_s);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_ok_s) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok_s && !clr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end
endmodule

// File: rtl/upscale_stream_out.sv
// Output stage of the 3x upscaler: buffers the unthrottled pixel stream and
// presents it as a ready/valid video stream with SOF/EOL markers and frame status.
module upscale_stream_out
  import upscale_stream_out_pkg::*;
#(
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 72,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PIX_W-1:0]                s_pixel,
  input  logic                            s_valid,
  input  logic                            flush,
  output logic [PIX_W-1:0]                m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tuser,
  output logic                            m_tlast,
  output logic                            frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            overflow
);
  localparam int OUT_W = out_dim(IMG_W);
  localparam int OUT_H = out_dim(IMG_H);
  localparam int XW    = $clog2(OUT_W);
  localparam int YW    = $clog2(OUT_H);

  logic          full_s, empty_s, rd_s;
  logic [XW-1:0] x_cnt_q, x_cnt_d;
  logic [YW-1:0] y_cnt_q, y_cnt_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;

  sync_fifo_fwft #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (s_valid),
    .wr_data (s_pixel),
    .rd_en   (m_tready),
    .rd_data (m_tdata),
    .full    (full_s),
    .empty   (empty_s),
    .level   (fifo_level)
  );

  assign m_tvalid   = !empty_s;
  assign rd_s       = m_tvalid && m_tready;
  assign m_tuser    = m_tvalid && (x_cnt_q == XW'(0)) && (y_cnt_q == YW'(0));
  assign m_tlast    = m_tvalid && (x_cnt_q == XW'(OUT_W - 1));
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

  always_comb begin
    x_cnt_d      = x_cnt_q;
    y_cnt_d      = y_cnt_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    if (flush) begin
      x_cnt_d    = '0;
      y_cnt_d    = '0;
      overflow_d = 1'b0;
    end else begin
      // Raster position follows accepted beats only, never writes.
      if (rd_s) begin
        if (x_cnt_q == XW'(OUT_W - 1)) begin
          x_cnt_d = '0;
          if (y_cnt_q == YW'(OUT_H - 1)) begin
            y_cnt_d      = '0;
            frame_done_d = 1'b1;
          end else begin
            y_cnt_d = y_cnt_q + YW'(1);
          end
        end else begin
          x_cnt_d = x_cnt_q + XW'(1);
        end
      end else begin
        x_cnt_d = x_cnt_q;
      end
      if (s_valid && full_s && !rd_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end
endmodule

// File: tb/tb_upscale_stream_out.sv
// Scoreboard bench for upscale_stream_out at IMG 4x2 (OUT 12x6), FIFO depth 8.
// Stimulus pushes expected beats; a negedge monitor pops and compares accepted beats.
module tb_upscale_stream_out;
  localparam int OUT_W = 12;
  localparam int OUT_H = 6;

  typedef struct {
    logic [23:0] d;
    logic        u;
    logic        l;
    logic        f;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] s_pixel = 24'h000000;
  logic        s_valid = 1'b0;
  logic        flush = 1'b0;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tuser;
  logic        m_tlast;
  logic        frame_done;
  logic [3:0]  fifo_level;
  logic        overflow;

  beat_t q[$];
  int    chk_cnt = 0;
  int    pass_cnt = 0;
  int    px = 0;
  int    py = 0;
  int    beats = 0;
  int    fd_count = 0;
  int    cyc = 0;
  int    fd_cyc[2];
  logic  pending_fd = 1'b0;

  upscale_stream_out #(.IMG_W(4), .IMG_H(2), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_pixel(s_pixel), .s_valid(s_valid), .flush(flush),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tuser(m_tuser),
    .m_tlast(m_tlast), .frame_done(frame_done), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one input pixel; when it should be stored, record the beat it must become.
  task automatic send(input logic [23:0] pix, input bit accept);
    beat_t e;
    s_valid = 1'b1;
    s_pixel = pix;
    if (accept) begin
      e.d = pix;
      e.u = (px == 0 && py == 0);
      e.l = (px == OUT_W - 1);
      e.f = (px == OUT_W - 1 && py == OUT_H - 1);
      q.push_back(e);
      if (px == OUT_W - 1) begin
        px = 0;
        py = (py == OUT_H - 1) ? 0 : py + 1;
      end else begin
        px++;
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sb_clear();
    q.delete();
    px = 0;
    py = 0;
    pending_fd = 1'b0;
  endtask

  task automatic do_flush();
    s_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb_clear();
  endtask

  // Monitor: compare accepted beats in order and the timing of frame_done.
  always @(negedge clk) begin
    if (!rst_n) begin
      pending_fd = 1'b0;
    end else begin
      if (frame_done || pending_fd) chk("frame_done", 32'(frame_done), 32'(pending_fd));
      if (frame_done) begin
        if (fd_count < 2) fd_cyc[fd_count] = cyc;
        fd_count++;
      end
      pending_fd = 1'b0;
      if (m_tvalid && m_tready) begin
        beats++;
        if (q.size() == 0) begin
          chk("unexpected_beat", 32'(m_tdata), 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("beat_data", 32'(m_tdata), 32'(e.d));
          chk("beat_tuser", 32'(m_tuser), 32'(e.u));
          chk("beat_tlast", 32'(m_tlast), 32'(e.l));
          pending_fd = e.f && !flush;
        end
      end
    end
  end

  initial begin
    #12;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_flags", {29'd0, m_tuser, m_tlast, frame_done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: streaming, no stall
    m_tready = 1'b1;
    beats = 0;
    fd_count = 0;
    chk("t1_idle_valid", 32'(m_tvalid), 32'd0);
    for (int i = 0; i < 72; i++) begin
      send(24'h100000 + 24'(i), 1'b1);
      if (i == 0) begin
        chk("t1_latency_valid", 32'(m_tvalid), 32'd1);
        chk("t1_latency_data", 32'(m_tdata), 32'h100000);
      end
    end
    idle(4);
    chk("t1_beats", 32'(beats), 32'd72);
    chk("t1_fd_count", 32'(fd_count), 32'd1);
    chk("t1_overflow", 32'(overflow), 32'd0);

    // 2: backpressure within depth
    do_flush();
    m_tready = 1'b0;
    for (int i = 1; i <= 8; i++) send(24'(i), 1'b1);
    s_valid = 1'b0;
    chk("t2_level_full", 32'(fifo_level), 32'd8);
    chk("t2_head_data", 32'(m_tdata), 32'h000001);
    chk("t2_head_tuser", 32'(m_tuser), 32'd1);

    // 3: overflow while full and stalled
    send(24'h0000AA, 1'b0);
    s_valid = 1'b0;
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_level", 32'(fifo_level), 32'd8);
    tick();
    chk("t3_head_held", 32'(m_tdata), 32'h000001);
    m_tready = 1'b1;
    idle(10);
    chk("t3_drained", 32'(fifo_level), 32'd0);
    chk("t3_sb_empty", 32'(q.size()), 32'd0);
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);
    do_flush();
    chk("t3_flush_ovf", 32'(overflow), 32'd0);

    // 4: full with simultaneous read and write
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(24'h200000 + 24'(i), 1'b1);
    m_tready = 1'b1;
    send(24'h2000FF, 1'b1);
    s_valid = 1'b0;
    chk("t4_level", 32'(fifo_level), 32'd8);
    chk("t4_overflow", 32'(overflow), 32'd0);
    idle(10);
    chk("t4_drained", 32'(fifo_level), 32'd0);
    chk("t4_sb_empty", 32'(q.size()), 32'd0);

    // 5a: asynchronous reset mid-frame
    do_flush();
    for (int i = 0; i < 30; i++) send(24'h300000 + 24'(i), 1'b1);
    s_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("t5_rst_tdata", 32'(m_tdata), 32'd0);
    chk("t5_rst_level", 32'(fifo_level), 32'd0);
    chk("t5_rst_flags", {28'd0, m_tuser, m_tlast, frame_done, overflow}, 32'd0);
    sb_clear();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send(24'h3A0000, 1'b1);
    s_valid = 1'b0;
    chk("t5_rst_sof", 32'(m_tuser), 32'd1);
    idle(3);

    // 5b: flush mid-frame
    for (int i = 0; i < 30; i++) send(24'h400000 + 24'(i), 1'b1);
    do_flush();
    chk("t5_flush_tvalid", 32'(m_tvalid), 32'd0);
    chk("t5_flush_tdata", 32'(m_tdata), 32'd0);
    chk("t5_flush_level", 32'(fifo_level), 32'd0);
    send(24'h4A0000, 1'b1);
    s_valid = 1'b0;
    chk("t5_flush_sof", 32'(m_tuser), 32'd1);
    idle(3);

    // 6: two back-to-back frames
    do_flush();
    fd_count = 0;
    for (int i = 0; i < 144; i++) send(24'h500000 + 24'(i), 1'b1);
    idle(4);
    chk("t6_fd_count", 32'(fd_count), 32'd2);
    chk("t6_fd_spacing", 32'(fd_cyc[1] - fd_cyc[0]), 32'd72);
    chk("t6_sb_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
